// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Decode-to-execute issue stage. Turns an RV64I instruction plus its register
// operands into an ALU select code and two operands. The result is held in a
// single-entry ID/EX register with valid/ready backpressure and flush.

module alu_issue_stage #(
  parameter int DWIDTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DWIDTH-1:0] in_pc,
  input  logic [DWIDTH-1:0] in_rs1_data,
  input  logic [DWIDTH-1:0] in_rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        alu_sel,
  output logic [DWIDTH-1:0] alu_input_A,
  output logic [DWIDTH-1:0] alu_input_B,
  output logic [4:0]        out_rd,
  output logic              out_wb_en,
  output logic              out_illegal
);

  // Major opcodes handled by this stage
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;

  // ALU select codes shared with the execute stage
  localparam logic [4:0] SEL_ADD   = 5'd0;
  localparam logic [4:0] SEL_SUB   = 5'd1;
  localparam logic [4:0] SEL_SLL   = 5'd2;
  localparam logic [4:0] SEL_SLT   = 5'd3;
  localparam logic [4:0] SEL_SLTU  = 5'd4;
  localparam logic [4:0] SEL_XOR   = 5'd5;
  localparam logic [4:0] SEL_SRL   = 5'd6;
  localparam logic [4:0] SEL_SRA   = 5'd7;
  localparam logic [4:0] SEL_OR    = 5'd8;
  localparam logic [4:0] SEL_AND   = 5'd9;
  localparam logic [4:0] SEL_ADDW  = 5'd10;
  localparam logic [4:0] SEL_SUBW  = 5'd11;
  localparam logic [4:0] SEL_SLLW  = 5'd12;
  localparam logic [4:0] SEL_SRLW  = 5'd13;
  localparam logic [4:0] SEL_SRAW  = 5'd14;
  localparam logic [4:0] SEL_ADDI  = 5'd15;
  localparam logic [4:0] SEL_SLLI  = 5'd16;
  localparam logic [4:0] SEL_SLTI  = 5'd17;
  localparam logic [4:0] SEL_SLTIU = 5'd18;
  localparam logic [4:0] SEL_XORI  = 5'd19;
  localparam logic [4:0] SEL_SRLI  = 5'd20;
  localparam logic [4:0] SEL_SRAI  = 5'd21;
  localparam logic [4:0] SEL_ORI   = 5'd22;
  localparam logic [4:0] SEL_ANDI  = 5'd23;
  localparam logic [4:0] SEL_ADDIW = 5'd24;
  localparam logic [4:0] SEL_SLLIW = 5'd25;
  localparam logic [4:0] SEL_SRLIW = 5'd26;
  localparam logic [4:0] SEL_SRAIW = 5'd27;
  localparam logic [4:0] SEL_JALR  = 5'd28;
  localparam logic [4:0] SEL_AADD  = 5'd31;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [5:0] funct6;
  logic [4:0] rd;

  logic [DWIDTH-1:0] imm_i;
  logic [DWIDTH-1:0] imm_s;
  logic [DWIDTH-1:0] imm_b;
  logic [DWIDTH-1:0] imm_j;
  logic [DWIDTH-1:0] imm_u;
  logic [DWIDTH-1:0] shamt_imm6;
  logic [DWIDTH-1:0] shamt_imm5;
  logic [DWIDTH-1:0] shamt_rs2_6;
  logic [DWIDTH-1:0] shamt_rs2_5;

  logic [4:0]        dec_sel;
  logic [DWIDTH-1:0] dec_a;
  logic [DWIDTH-1:0] dec_b;
  logic              dec_illegal;
  logic              dec_writes;
  logic              dec_wb;
  logic              accept;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign funct6 = in_instr[31:26];
  assign rd     = in_instr[11:7];

  // Every immediate is sign-extended from instr[31]; shift amounts are zero-extended
  assign imm_i       = {{(DWIDTH-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s       = {{(DWIDTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b       = {{(DWIDTH-13){in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j       = {{(DWIDTH-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u       = {{(DWIDTH-32){in_instr[31]}}, in_instr[31:12], 12'b0};
  assign shamt_imm6  = {{(DWIDTH-6){1'b0}}, in_instr[25:20]};
  assign shamt_imm5  = {{(DWIDTH-5){1'b0}}, in_instr[24:20]};
  assign shamt_rs2_6 = {{(DWIDTH-6){1'b0}}, in_rs2_data[5:0]};
  assign shamt_rs2_5 = {{(DWIDTH-5){1'b0}}, in_rs2_data[4:0]};

  // Decode opcode/funct fields into select code and operands; unknown encodings are flagged illegal
  always_comb begin
    dec_sel     = SEL_ADD;
    dec_a       = '0;
    dec_b       = '0;
    dec_illegal = 1'b0;
    dec_writes  = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_writes = 1'b1;
        dec_a      = in_rs1_data;
        dec_b      = in_rs2_data;
        case (funct3)
          3'd0: begin
            if (funct7 == 7'h00)      dec_sel = SEL_ADD;
            else if (funct7 == 7'h20) dec_sel = SEL_SUB;
            else                      dec_illegal = 1'b1;
          end
          3'd1: begin
            dec_sel     = SEL_SLL;
            dec_b       = shamt_rs2_6;
            dec_illegal = (funct7 != 7'h00);
          end
          3'd2: begin dec_sel = SEL_SLT;  dec_illegal = (funct7 != 7'h00); end
          3'd3: begin dec_sel = SEL_SLTU; dec_illegal = (funct7 != 7'h00); end
          3'd4: begin dec_sel = SEL_XOR;  dec_illegal = (funct7 != 7'h00); end
          3'd5: begin
            dec_b = shamt_rs2_6;
            if (funct7 == 7'h00)      dec_sel = SEL_SRL;
            else if (funct7 == 7'h20) dec_sel = SEL_SRA;
            else                      dec_illegal = 1'b1;
          end
          3'd6: begin dec_sel = SEL_OR;  dec_illegal = (funct7 != 7'h00); end
          default: begin dec_sel = SEL_AND; dec_illegal = (funct7 != 7'h00); end
        endcase
      end
      OPC_OP_32: begin
        dec_writes = 1'b1;
        dec_a      = in_rs1_data;
        dec_b      = in_rs2_data;
        case (funct3)
          3'd0: begin
            if (funct7 == 7'h00)      dec_sel = SEL_ADDW;
            else if (funct7 == 7'h20) dec_sel = SEL_SUBW;
            else                      dec_illegal = 1'b1;
          end
          3'd1: begin
            dec_sel     = SEL_SLLW;
            dec_b       = shamt_rs2_5;
            dec_illegal = (funct7 != 7'h00);
          end
          3'd5: begin
            dec_b = shamt_rs2_5;
            if (funct7 == 7'h00)      dec_sel = SEL_SRLW;
            else if (funct7 == 7'h20) dec_sel = SEL_SRAW;
            else                      dec_illegal = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec_writes = 1'b1;
        dec_a      = in_rs1_data;
        dec_b      = imm_i;
        case (funct3)
          3'd0: dec_sel = SEL_ADDI;
          3'd1: begin
            dec_sel     = SEL_SLLI;
            dec_b       = shamt_imm6;
            dec_illegal = (funct6 != 6'h00);
          end
          3'd2: dec_sel = SEL_SLTI;
          3'd3: dec_sel = SEL_SLTIU;
          3'd4: dec_sel = SEL_XORI;
          3'd5: begin
            dec_b = shamt_imm6;
            if (funct6 == 6'h00)      dec_sel = SEL_SRLI;
            else if (funct6 == 6'h10) dec_sel = SEL_SRAI;
            else                      dec_illegal = 1'b1;
          end
          3'd6: dec_sel = SEL_ORI;
          default: dec_sel = SEL_ANDI;
        endcase
      end
      OPC_OP_IMM_32: begin
        dec_writes = 1'b1;
        dec_a      = in_rs1_data;
        dec_b      = imm_i;
        case (funct3)
          3'd0: dec_sel = SEL_ADDIW;
          3'd1: begin
            dec_sel     = SEL_SLLIW;
            dec_b       = shamt_imm5;
            dec_illegal = (funct7 != 7'h00);
          end
          3'd5: begin
            dec_b = shamt_imm5;
            if (funct7 == 7'h00)      dec_sel = SEL_SRLIW;
            else if (funct7 == 7'h20) dec_sel = SEL_SRAIW;
            else                      dec_illegal = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_JALR: begin
        dec_writes  = 1'b1;
        dec_sel     = SEL_JALR;
        dec_a       = in_rs1_data;
        dec_b       = imm_i;
        dec_illegal = (funct3 != 3'd0);
      end
      OPC_LUI: begin
        dec_writes = 1'b1;
        dec_sel    = SEL_AADD;
        dec_b      = imm_u;
      end
      OPC_AUIPC: begin
        dec_writes = 1'b1;
        dec_sel    = SEL_AADD;
        dec_a      = in_pc;
        dec_b      = imm_u;
      end
      OPC_JAL: begin
        dec_writes = 1'b1;
        dec_sel    = SEL_AADD;
        dec_a      = in_pc;
        dec_b      = imm_j;
      end
      OPC_BRANCH: begin
        dec_sel     = SEL_AADD;
        dec_a       = in_pc;
        dec_b       = imm_b;
        dec_illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_LOAD: begin
        dec_writes  = 1'b1;
        dec_sel     = SEL_AADD;
        dec_a       = in_rs1_data;
        dec_b       = imm_i;
        dec_illegal = (funct3 == 3'd7);
      end
      OPC_STORE: begin
        dec_sel     = SEL_AADD;
        dec_a       = in_rs1_data;
        dec_b       = imm_s;
        dec_illegal = (funct3[2] == 1'b1);
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_sel    = SEL_ADD;
      dec_a      = '0;
      dec_b      = '0;
      dec_writes = 1'b0;
    end
  end

  assign dec_wb   = dec_writes && (rd != 5'd0);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // ID/EX register: reset beats flush, flush beats capture, otherwise hold or drain
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      alu_sel     <= '0;
      alu_input_A <= '0;
      alu_input_B <= '0;
      out_rd      <= '0;
      out_wb_en   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      alu_sel     <= dec_sel;
      alu_input_A <= dec_a;
      alu_input_B <= dec_b;
      out_rd      <= rd;
      out_wb_en   <= dec_wb;
      out_illegal <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue stage that produces the ALU's operation select and operands. It accepts one decoded-register-read instruction per handshake, converts opcode/funct fields into the 5-bit ALU select code, and builds operands A and B from rs1/rs2 data, PC or immediate. Results sit in a single-entry pipeline register (the ID/EX boundary) with valid/ready backpressure and flush, feeding the ALU directly.

## Interface
- DWIDTH, 64: datapath width of operands and PC.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard held and incoming instruction (branch redirect).
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; combinational, equals !out_valid | out_ready.
- in_instr  in  32  RV64I instruction word.
- in_pc  in  DWIDTH  instruction PC.
- in_rs1_data  in  DWIDTH  rs1 register value.
- in_rs2_data  in  DWIDTH  rs2 register value.
- out_valid  out  1  registered outputs hold a valid instruction.
- out_ready  in  1  execute stage consumes this cycle.
- alu_sel  out  5  ALU operation code.
- alu_input_A  out  DWIDTH  operand A.
- alu_input_B  out  DWIDTH  operand B.
- out_rd  out  5  destination register, instr[11:7].
- out_wb_en  out  1  rd write expected (R, I, LOAD, JAL, JALR, LUI, AUIPC, and rd != 0).
- out_illegal  out  1  unsupported encoding.

## Operation
- alu_sel codes, fixed: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, ADDW 10, SUBW 11, SLLW 12, SRLW 13, SRAW 14, ADDI 15, SLLI 16, SLTI 17, SLTIU 18, XORI 19, SRLI 20, SRAI 21, ORI 22, ANDI 23, ADDIW 24, SLLIW 25, SRLIW 26, SRAIW 27, JALR 28, address-add 31.
- OP (0110011), funct3/funct7[5]: A=rs1; B=rs2, except shifts use B=zext(rs2[5:0]).
- OP-32 (0111011): A=rs1; ADDW/SUBW B=rs2; shifts B=zext(rs2[4:0]).
- OP-IMM (0010011): A=rs1; B=sext(instr[31:20]); SLLI/SRLI/SRAI B=zext(instr[25:20]), SRAI when instr[30]=1.
- OP-IMM-32 (0011011): A=rs1; ADDIW B=sext(imm12); shifts B=zext(instr[24:20]).
- JALR (1100111): sel 28, A=rs1, B=sext(imm_i).
- sel 31 group: LUI A=0, B=sext({instr[31:12],12'b0}); AUIPC A=pc, B=same U-imm; JAL A=pc, B=sext(imm_j); BRANCH A=pc, B=sext(imm_b); LOAD A=rs1, B=sext(imm_i); STORE A=rs1, B=sext(imm_s).
- Any other opcode, or undefined funct3/funct7 combination: out_illegal=1, alu_sel=0, A=B=0, out_wb_en=0; still flows through the handshake.
- All immediates sign-extended to DWIDTH from bit 31 of instr.

## Timing
- Reset (rst=1 at edge): out_valid=0, alu_sel=0, alu_input_A=0, alu_input_B=0, out_rd=0, out_wb_en=0, out_illegal=0. Reset mid-transfer drops the held instruction.
- Accept when in_valid & in_ready; registered outputs update at that edge; latency 1 cycle.
- out_valid next = (in_valid & in_ready) | (out_valid & !out_ready), then forced 0 by flush or rst.
- Stall: out_valid & !out_ready holds all outputs stable; in_ready=0.
- Simultaneous consume and accept: back-to-back, one instruction per cycle, no bubble.
- flush=1: out_valid=0 next cycle; any instruction offered that cycle is discarded. Data registers may keep stale values when out_valid=0.
- rst has priority over flush; flush over capture.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0 and all outputs 0 one cycle after release until first accept.
- R-type: SUB x3,x1,x2 (0x402081B3), rs1=10, rs2=3 -> next cycle out_valid=1, alu_sel=1, A=10, B=3, out_rd=3, out_wb_en=1.
- Shift masking: SRAW with rs2=0x7F -> alu_sel=14, B=0x1F; SRAI imm 63 (instr[25:20]=0x3F, instr[30]=1) -> alu_sel=21, B=63.
- Immediates: ADDI imm=-1 -> alu_sel=15, B=0xFFFF_FFFF_FFFF_FFFF; AUIPC imm 0x80000 at pc=0x1000 -> sel 31, A=0x1000, B=0xFFFF_FFFF_8000_0000.
- Backpressure: stream 4 instructions, out_ready low 3 cycles mid-stream -> outputs stable, in_ready=0, no loss/duplication, order preserved, full throughput when out_ready=1.
- Flush/illegal: flush while stalled with valid output -> out_valid=0 next cycle; opcode 0x7F -> out_illegal=1, alu_sel=0, out_wb_en=0.
